// File: rtl/prog_loader.sv
// prog_loader: streams a counted, checksummed byte program into instruction memory while holding the CPU in reset
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [4:0]  imem_addr,
  output logic [18:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  words_loaded
);
  typedef enum logic [3:0] {IDLE, COUNT, B0, B1, B2, WRITE, CSUM, DONE, ERR} state_t;
  state_t      state;
  logic [5:0]  n;
  logic [7:0]  acc;
  logic [18:0] word;
  logic [4:0]  addr;
  logic [5:0]  wl;
  // Load sequencer: a byte is consumed whenever rx_valid is high in a receiving state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      n     <= '0;
      acc   <= '0;
      word  <= '0;
      addr  <= '0;
      wl    <= '0;
    end else case (state)
      IDLE, DONE, ERR: if (start) begin
        state <= COUNT;
        wl    <= '0;
        addr  <= '0;
        acc   <= '0;
      end
      COUNT: if (rx_valid) begin
        n     <= rx_data[5:0];
        state <= (rx_data >= 8'd1 && rx_data <= 8'd32) ? B0 : ERR;
      end
      B0: if (rx_valid) begin
        word[18:16] <= rx_data[2:0];
        acc         <= acc ^ rx_data;
        state       <= (rx_data[7:3] != 5'd0) ? ERR : B1;
      end
      B1: if (rx_valid) begin
        word[15:8] <= rx_data;
        acc        <= acc ^ rx_data;
        state      <= B2;
      end
      B2: if (rx_valid) begin
        word[7:0] <= rx_data;
        acc       <= acc ^ rx_data;
        state     <= WRITE;
      end
      WRITE: begin
        addr  <= (addr == 5'd31) ? addr : addr + 5'd1;
        wl    <= wl + 6'd1;
        state <= (wl + 6'd1 == n) ? CSUM : B0;
      end
      CSUM: if (rx_valid) state <= (rx_data == acc) ? DONE : ERR;
      default: state <= IDLE;
    endcase
  assign rx_ready     = state inside {COUNT, B0, B1, B2, CSUM};
  assign imem_we      = state == WRITE;
  assign imem_addr    = addr;
  assign imem_wdata   = word;
  assign cpu_hold     = state != DONE;
  assign busy         = !(state inside {IDLE, DONE, ERR});
  assign done         = state == DONE;
  assign err          = state == ERR;
  assign words_loaded = wl;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scoreboard bench for the program loader
module tb_prog_loader;
  logic        clk, reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_hold, busy, done, err;
  logic [4:0]  imem_addr;
  logic [18:0] imem_wdata;
  logic [5:0]  words_loaded;
  int checks = 0, failures = 0, nwr = 0, stalls = 0, base;
  logic [23:0] exp_q[$];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // write scoreboard and stall monitor
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset === 1'b1 && imem_we === 1'b1) begin
      nwr++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      checks++;
      assert ({imem_addr, imem_wdata} === e) else begin
        failures++;
        $error("FAIL imem_write observed=%06h expected=%06h", {imem_addr, imem_wdata}, e);
      end
    end
    if (rx_valid && !rx_ready && busy) stalls++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    logic ok = 0;
    int g = (maxgap != 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1;
        break;
      end
    end
    chk("rx_accept", ok, 1);
    @(posedge clk);
    #1 rx_valid = 0;
    rx_data = 0;
  endtask

  task automatic send_normal(input logic [7:0] last, input int maxgap);
    logic [7:0] s[8] = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h60};
    s[7] = last;
    for (int i = 0; i < 8; i++) send(s[i], maxgap);
  endtask

  task automatic push_normal();
    exp_q.push_back({5'd0, 19'h12345});
    exp_q.push_back({5'd1, 19'h00007});
  endtask

  initial begin
    logic [18:0] w;
    logic [7:0]  cs;
    reset = 0; start = 0; rx_valid = 0; rx_data = 0;
    #12 chk_reset("por");
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 chk_reset("idle");

    // normal load
    base = nwr;
    push_normal();
    do_start();
    chk("count_busy", busy, 1);
    send_normal(8'h60, 0);
    chk("norm_writes", nwr - base, 2);
    chk("norm_done", done, 1);
    chk("norm_err", err, 0);
    chk("norm_cpu_hold", cpu_hold, 0);
    chk("norm_busy", busy, 0);
    chk("norm_wl", words_loaded, 2);
    chk("norm_q_empty", exp_q.size(), 0);

    // count errors
    base = nwr;
    do_start();
    chk("restart_done_clr", done, 0);
    send(8'h00, 0);
    chk("cnt0_err", err, 1);
    chk("cnt0_cpu_hold", cpu_hold, 1);
    chk("cnt0_wl", words_loaded, 0);
    do_start();
    send(8'h21, 0);
    chk("cnt21_err", err, 1);
    chk("cnt21_done", done, 0);
    chk("cnt21_cpu_hold", cpu_hold, 1);
    chk("cnt_writes", nwr - base, 0);

    // bad checksum
    base = nwr;
    push_normal();
    do_start();
    chk("restart_err_clr", err, 0);
    send_normal(8'h61, 0);
    chk("csum_writes", nwr - base, 2);
    chk("csum_err", err, 1);
    chk("csum_done", done, 0);
    chk("csum_cpu_hold", cpu_hold, 1);
    chk("csum_wl", words_loaded, 2);

    // bad reserved bits
    base = nwr;
    do_start();
    send(8'h01, 0);
    send(8'h08, 0);
    chk("rsv_err", err, 1);
    chk("rsv_wl", words_loaded, 0);
    chk("rsv_writes", nwr - base, 0);

    // backpressure with rx_valid held high
    base = nwr;
    push_normal();
    do_start();
    stalls = 0;
    send_normal(8'h60, 0);
    chk("bp_stalls", stalls, 2);
    chk("bp_writes", nwr - base, 2);
    chk("bp_done", done, 1);

    // random gaps, start pulsed while busy is ignored
    base = nwr;
    push_normal();
    do_start();
    send(8'h02, 3);
    start = 1;
    send(8'h01, 3); send(8'h23, 3); send(8'h45, 3);
    send(8'h00, 3); send(8'h00, 3); send(8'h07, 3);
    start = 0;
    send(8'h60, 3);
    chk("gap_writes", nwr - base, 2);
    chk("gap_done", done, 1);
    chk("gap_wl", words_loaded, 2);
    chk("gap_q_empty", exp_q.size(), 0);

    // reset mid-load
    base = nwr;
    do_start();
    send(8'h02, 0); send(8'h01, 0); send(8'h23, 0);
    #2 reset = 0;
    #1 chk_reset("midrst");
    repeat (2) @(posedge clk);
    #3 reset = 1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_writes", nwr - base, 0);
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_hold", cpu_hold, 1);
    push_normal();
    do_start();
    send_normal(8'h60, 0);
    chk("post_rst_done", done, 1);
    chk("post_rst_writes", nwr - base, 2);

    // full 32-word load
    base = nwr;
    cs = 0;
    do_start();
    send(8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      w = 19'($urandom());
      exp_q.push_back({5'(i), w});
      cs = cs ^ {5'd0, w[18:16]} ^ w[15:8] ^ w[7:0];
      send({5'd0, w[18:16]}, 1);
      send(w[15:8], 1);
      send(w[7:0], 1);
    end
    send(cs, 0);
    chk("n32_writes", nwr - base, 32);
    chk("n32_wl", words_loaded, 32);
    chk("n32_addr_nowrap", imem_addr, 31);
    chk("n32_done", done, 1);
    chk("n32_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  in  1  system clock; all state changes on the rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-003 start  in  1  load request; sampled only in IDLE, DONE or ERR.
REQ-004 rx_data  in  8  inbound program byte.
REQ-005 rx_valid  in  1  rx_data is valid.
REQ-006 rx_ready  out  1  loader accepts a byte; a transfer occurs on a rising edge when rx_valid=1 and rx_ready=1.
REQ-007 imem_we  out  1  one-cycle instruction-memory write strobe.
REQ-008 imem_addr  out  5  instruction-memory write address, 0..31.
REQ-009 imem_wdata  out  19  instruction word to write.
REQ-010 cpu_hold  out  1  holds the CPU in reset while 1.
REQ-011 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-012 done  out  1  last load completed correctly.
REQ-013 err  out  1  last load failed.
REQ-014 words_loaded  out  6  number of words written in the current or last load, 0..32.

Function
REQ-015 Byte stream, in order:
- count byte N, valid range 1..32;
- N words, 3 bytes each, MSB first;
- one checksum byte.
REQ-016 Word byte0: bits[2:0] map to word[18:16]; bits[7:3] SHALL be 0. Byte1 maps to word[15:8]. Byte2 maps to word[7:0].
REQ-017 The checksum SHALL equal the XOR of all 3N word bytes; the count byte is excluded.
REQ-018 FSM states: IDLE, COUNT, B0, B1, B2, WRITE, CSUM, DONE, ERR.
REQ-019 IDLE/DONE/ERR with start=1 -> COUNT. This clears done, err, words_loaded, the address counter and the checksum accumulator.
REQ-020 COUNT with a byte accepted:
- N in 1..32 -> B0, and N is latched;
- otherwise -> ERR.
REQ-021 B0 with a byte accepted:
- bits[7:3] != 0 -> ERR;
- otherwise -> B1.
REQ-022 B1 with a byte accepted -> B2. B2 with a byte accepted -> WRITE.
REQ-023 WRITE lasts exactly one cycle:
- imem_we=1, imem_addr = current address, imem_wdata = assembled word;
- then the address and words_loaded increment;
- next state is CSUM if words_loaded+1 == N, otherwise B0.
REQ-024 CSUM with a byte accepted:
- byte equals the accumulator -> DONE;
- otherwise -> ERR.
REQ-025 rx_ready=1 only in COUNT, B0, B1, B2 and CSUM; it is 0 in WRITE, IDLE, DONE and ERR. Bytes offered while rx_ready=0 are not consumed.
REQ-026 With rx_valid=0 the FSM holds its state indefinitely; there is no timeout.
REQ-027 The accumulator XORs each accepted word byte in the same cycle the byte is accepted.
REQ-028 imem_we=0 in all states except WRITE. A word aborted by ERR is never written. Words written before an error remain in memory.
REQ-029 cpu_hold=0 only in DONE; it is 1 in every other state, including IDLE after reset.
REQ-030 done=1 only in DONE and err=1 only in ERR. Both are held until the next start.
REQ-031 N=32: the address runs 0..31 and does not wrap; words_loaded reaches 32.
REQ-032 start asserted while busy=1 is ignored.
REQ-033 A byte accepted in the same cycle that start=1 in DONE/ERR is impossible, because rx_ready=0 in those states.

Reset
REQ-034 While reset=0, the block SHALL drive:
- state = IDLE;
- rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_hold=1, busy=0, done=0, err=0, words_loaded=0;
- accumulator, N and the assembly register = 0.
REQ-035 Reset asserted mid-load aborts the load immediately with no further memory write. After reset is released, the block waits in IDLE for start.

Verification
REQ-036 Normal load: start, then bytes 02, 01, 23, 45, 00, 00, 07, 60 -> two writes: addr0=0x12345 and addr1=0x00007, one imem_we pulse each; then done=1, cpu_hold=0, words_loaded=2.
REQ-037 Count error: start, then count byte 00 -> ERR, err=1, no imem_we, cpu_hold=1. Repeat with 21 (hex) -> same response.
REQ-038 Bad checksum: the REQ-036 stream with final byte 61 -> both words written, then err=1, done=0, cpu_hold=1.
REQ-039 Bad reserved bits: start, 01, 08 -> ERR on the 08 byte, imem_we never asserted, words_loaded=0.
REQ-040 Backpressure and gaps: the REQ-036 stream with rx_valid held high throughout -> rx_ready=0 for exactly one cycle after each third word byte, and no byte is lost. The same stream with random rx_valid gaps -> identical writes.
REQ-041 Reset mid-load: reset=0 after byte 23 of REQ-036 -> all outputs at REQ-034 values asynchronously, no write. A following start plus the full stream -> normal completion.
